// File: rtl/counter_pkg.sv
// counter_pkg: shared mode/direction encodings and width helper for the counter family
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    localparam logic CNT_DN = 1'b0;
    localparam logic CNT_UP = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: divides enabled cycles by presc_div+1, emitting a one-cycle tick
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic               zero,
    input  logic [PRESC_W-1:0] presc_div,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = en && (cnt == presc_div);

    // phase counter: frozen while disabled, restarts after each tick
    always_ff @(posedge clk) begin
        if (clr || zero) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + PRESC_W'(1);
    end

endmodule

// File: rtl/counter_updn.sv
// counter_updn: modulo up/down counter with load, wrap/saturate, tc pulse and sticky ovf; COUNTER_UPDN_PRESCALE_EN adds a prescaler
module counter_updn
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SAT_MODE = CNT_WRAP,
    parameter int PRESC_W  = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic               up,
`ifdef COUNTER_UPDN_PRESCALE_EN
    input  logic [PRESC_W-1:0] presc_div,
`endif
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   countv,
    output logic               tc,
    output logic               ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || clog2(MODULUS) > WIDTH || PRESC_W < 1) begin : g_bad_cfg
        $error("counter_updn: illegal WIDTH/MODULUS/PRESC_W combination");
    end

    logic             step;
    logic             term;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ld;

`ifdef COUNTER_UPDN_PRESCALE_EN
    counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .zero      (load),
        .presc_div (presc_div),
        .tick      (step)
    );
`else
    assign step = en;
`endif

    // terminal detection, next step value and clamped load value
    always_comb begin
        term = (up == CNT_UP) ? (countv == MAX) : (countv == '0);
        nxt  = (SAT_MODE == CNT_SAT && term) ? countv
             : (up == CNT_UP) ? (term ? '0 : countv + WIDTH'(1))
             : (term ? MAX : countv - WIDTH'(1));
        ld   = (load_val > MAX) ? MAX : load_val;
    end

    // count register with clr > load > step > hold priority
    always_ff @(posedge clk) begin
        if (clr) begin
            countv <= '0;
            tc     <= 1'b0;
            ovf    <= 1'b0;
        end else if (load) begin
            countv <= ld;
            tc     <= 1'b0;
        end else if (step) begin
            countv <= nxt;
            tc     <= term;
            ovf    <= ovf | term;
        end else begin
            tc     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_updn.sv
// tb_counter_updn: directed checks of wrap and saturate counters (plus prescaler when COUNTER_UPDN_PRESCALE_EN is defined)
module tb_counter_updn;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       en = 1'b1;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] countv, countv_s;
    logic       tc, tc_s, ovf, ovf_s;
`ifdef COUNTER_UPDN_PRESCALE_EN
    logic [3:0] presc_div = 4'd0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    counter_updn #(.WIDTH(4), .MODULUS(10), .SAT_MODE(0)) dut (
        .clk(clk), .clr(clr), .en(en), .up(up),
`ifdef COUNTER_UPDN_PRESCALE_EN
        .presc_div(presc_div),
`endif
        .load(load), .load_val(load_val),
        .countv(countv), .tc(tc), .ovf(ovf)
    );

    counter_updn #(.WIDTH(4), .MODULUS(10), .SAT_MODE(1)) dut_s (
        .clk(clk), .clr(clr), .en(en), .up(up),
`ifdef COUNTER_UPDN_PRESCALE_EN
        .presc_div(presc_div),
`endif
        .load(load), .load_val(load_val),
        .countv(countv_s), .tc(tc_s), .ovf(ovf_s)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_cnt", countv, 0);
            check("rst_tc", tc, 0);
            check("rst_ovf", ovf, 0);
        end
        clr = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            check("up_cnt", countv, i % 10);
            check("up_tc", tc, (i == 10) ? 1 : 0);
            check("up_ovf", ovf, (i >= 10) ? 1 : 0);
        end
        load = 1'b1; load_val = 4'd2; up = 1'b0;
        cyc();
        check("ld_cnt", countv, 2);
        check("ld_tc", tc, 0);
        check("ld_ovf_kept", ovf, 1);
        load = 1'b0;
        begin
            int exp_dn[4] = '{1, 0, 9, 8};
            for (int i = 0; i < 4; i++) begin
                cyc();
                check("dn_cnt", countv, exp_dn[i]);
                check("dn_tc", tc, (i == 2) ? 1 : 0);
            end
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("hold_cnt", countv, 8);
            check("hold_tc", tc, 0);
        end
        en = 1'b1; load = 1'b1; load_val = 4'd12;
        cyc();
        check("clamp_cnt", countv, 9);
        check("clamp_tc", tc, 0);
        clr = 1'b1;
        cyc();
        check("clr_ld_cnt", countv, 0);
        check("clr_ld_ovf", ovf, 0);
        clr = 1'b0; load = 1'b0; up = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        check("pre_wrap", countv, 9);
        cyc();
        check("wrap_tc", tc, 1);
        clr = 1'b1;
        cyc();
        check("midclr_cnt", countv, 0);
        check("midclr_tc", tc, 0);
        check("midclr_ovf", ovf, 0);
        clr = 1'b0; load = 1'b1; load_val = 4'd8;
        cyc();
        check("sat_ld", countv_s, 8);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("sat_cnt", countv_s, 9);
            check("sat_tc", tc_s, (i >= 1) ? 1 : 0);
        end
        check("sat_ovf", ovf_s, 1);
        up = 1'b0;
        cyc();
        check("sat_dn_cnt", countv_s, 8);
        check("sat_dn_tc", tc_s, 0);
`ifdef COUNTER_UPDN_PRESCALE_EN
        clr = 1'b1; up = 1'b1; presc_div = 4'd2;
        cyc();
        clr = 1'b0;
        check("ps_init", countv, 0);
        begin
            int exp_ps[6] = '{0, 0, 1, 1, 1, 2};
            for (int i = 0; i < 6; i++) begin
                cyc();
                check("ps_cnt", countv, exp_ps[i]);
            end
        end
        cyc();
        en = 1'b0;
        cyc();
        cyc();
        check("ps_frz", countv, 2);
        en = 1'b1;
        cyc();
        check("ps_phase_a", countv, 2);
        cyc();
        check("ps_phase_b", countv, 3);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_updn.md
Name: counter_updn

Overview:
Parametrised successor to the team's 4-bit enable/clear counter. Counts up or down modulo a programmable modulus, with synchronous load, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. Used as the general-purpose event/timebase counter in the demo designs and as a building block for timers and dividers.

Parameters:
WIDTH, 8, counter width in bits
MODULUS, 256, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
SAT_MODE, 0, 0 = wrap at the terminal value, 1 = saturate (hold) at the terminal value
PRESC_W, 4, prescaler divide-value width; used only when the optional feature is compiled in

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous active-high reset/clear
en  in  1  count enable
up  in  1  direction: 1 = up, 0 = down
load  in  1  synchronous load strobe
load_val  in  WIDTH  value to load
countv  out  WIDTH  current count (registered)
tc  out  1  terminal-count pulse (registered)
ovf  out  1  sticky overflow/underflow flag (registered)

Behaviour:
- Reset is synchronous and active-high: while clr=1 at a rising edge -> countv=0, tc=0, ovf=0, prescaler=0. clr takes priority over everything else.
- Priority per edge: clr > load > en step > hold.
- Load (clr=0, load=1): countv <= min(load_val, MODULUS-1); tc <= 0; ovf is unchanged; prescaler <= 0. Load overrides en in the same cycle.
- Terminal value: MODULUS-1 when up=1, 0 when up=0.
- Step (en=1, no clr/load, prescaler tick):
  - If countv is not at the terminal value: count ±1.
  - If countv is at the terminal value, this is a terminal event:
    - SAT_MODE=0: wrap to 0 (up) or MODULUS-1 (down).
    - SAT_MODE=1: countv holds.
  - On every terminal event: tc <= 1 and ovf <= 1.
- tc is high for exactly the cycle after each terminal event and 0 otherwise. In SAT_MODE=1 it therefore stays high continuously while en=1 and the count sits at the terminal value.
- ovf is sticky; only clr clears it.
- en=0: countv holds, tc <= 0.
- Direction change takes effect on the same edge; no pipeline. Latency from en to countv change is 1 cycle.
- Arithmetic is done in WIDTH bits. No intermediate value ever exceeds MODULUS-1; out-of-range load_val is clamped.
- Reset mid-count: countv returns to 0 on the next edge and the pending tc is dropped.

Optional Feature:
Macro COUNTER_UPDN_PRESCALE_EN.
- Defined:
  - Adds port presc_div (in, PRESC_W bits).
  - An internal prescaler counts enabled cycles. The main counter steps only when en=1 and prescaler == presc_div; the prescaler then returns to 0.
  - presc_div=0 steps on every enabled cycle.
  - clr and load zero the prescaler; en=0 freezes it.
  - A presc_div change applies from the next compare.
- Undefined: no presc_div port; the counter steps on every cycle with en=1.

Decomposition:
- Shared package counter_pkg:
  - Localparams for the SAT_MODE encodings (CNT_WRAP=0, CNT_SAT=1).
  - Direction constants (CNT_DN=0, CNT_UP=1).
  - Function clog2 for width checks.
- Natural sub-module counter_prescaler (clk, clr, en, zero, presc_div, tick), instantiated only under COUNTER_UPDN_PRESCALE_EN.
- The top holds the main count register, terminal detection, tc/ovf.

Test Plan:
- Config WIDTH=4, MODULUS=10, SAT_MODE=0: clr=1 for 3 cycles with en=1, up=1 -> countv=0, tc=0, ovf=0 throughout.
- Same config: en=1, up=1 from 0 for 12 cycles -> countv 1..9,0,1,2; tc high only in the cycle countv=0 follows 9; ovf=1 afterwards.
- Same config: load_val=2 with load=1, then up=0, en=1 -> countv 2,1,0,9,8; tc high one cycle with countv=9; en=0 for 3 cycles -> countv holds at 8, tc=0.
- Load rules:
  - load_val=12, load=1, en=1 -> countv=9 (clamped).
  - clr=1 and load=1 in the same cycle -> countv=0.
  - load after an overflow -> ovf stays 1.
- SAT_MODE=1, MODULUS=10: load 8, up=1, en=1 for 4 cycles -> countv 9,9,9,9 with tc high from the second edge onward; up=0 -> countv 8, tc=0.
- With COUNTER_UPDN_PRESCALE_EN, presc_div=2, en=1 -> countv increments every 3rd cycle (0,0,0,1,1,1,2); en=0 mid-period freezes the phase.
